// File: rtl/bcd_clock_pixel_driver.sv
// BCD time-of-day clock with 1 Hz prescaler that streams one LED colour per cycle.
// Trigger in IDLE -> first write next cycle; triggers during a frame collapse into one pending frame (no stall input).
module bcd_clock_pixel_driver #(
  parameter int          TICK_DIV     = 12000000,
  parameter bit          MODE_12H     = 1'b0,
  parameter bit          SHOW_SECONDS = 1'b1,
  parameter logic [23:0] ON_COLOR     = 24'h10_10_10,
  parameter logic [23:0] OFF_COLOR    = 24'h00_00_00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  load_h,
  input  logic [7:0]  load_m,
  input  logic [7:0]  load_s,
  input  logic        load_pm,
  output logic [7:0]  hh,
  output logic [7:0]  mm,
  output logic [7:0]  ss,
  output logic        pm,
  output logic        sec_pulse,
  output logic        load_err,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done
);

  localparam int          NUM_LEDS  = SHOW_SECONDS ? 24 : 16;
  localparam int          PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]  LAST_LED  = 8'(NUM_LEDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [3:0]          h_t, h_u, m_t, m_u, s_t, s_u;
  logic                pm_q;
  logic [PW-1:0]       presc;
  logic                pending;
  logic [NUM_LEDS-1:0] fb;

  logic                digits_ok, hour_ok, load_ok, tick, trig;
  logic [3:0]          n_h_t, n_h_u, n_m_t, n_m_u, n_s_t, n_s_u;
  logic                n_pm;
  logic [23:0]         digits;
  logic [NUM_LEDS-1:0] frame_bits;

  assign digits_ok = (load_h[7:4] <= 4'd9) && (load_h[3:0] <= 4'd9) &&
                     (load_m[7:4] <= 4'd5) && (load_m[3:0] <= 4'd9) &&
                     (load_s[7:4] <= 4'd5) && (load_s[3:0] <= 4'd9);

  assign hour_ok = MODE_12H ?
      ((load_h[7:4] == 4'd0 && load_h[3:0] != 4'd0) || (load_h[7:4] == 4'd1 && load_h[3:0] <= 4'd2)) :
      ((load_h[7:4] <= 4'd1) || (load_h[7:4] == 4'd2 && load_h[3:0] <= 4'd3));

  assign load_ok = load && digits_ok && hour_ok;
  // An accepted load restarts the second, so a coincident tick is dropped.
  assign tick    = (presc == PRESC_MAX) && !load_ok;
  assign trig    = tick || load_ok || pending;

  always_comb begin
    n_h_t = h_t;
    n_h_u = h_u;
    n_m_t = m_t;
    n_m_u = m_u;
    n_s_t = s_t;
    n_s_u = s_u;
    n_pm  = pm_q;
    if (load_ok) begin
      n_h_t = load_h[7:4];
      n_h_u = load_h[3:0];
      n_m_t = load_m[7:4];
      n_m_u = load_m[3:0];
      n_s_t = load_s[7:4];
      n_s_u = load_s[3:0];
      n_pm  = MODE_12H ? load_pm : 1'b0;
    end else if (tick) begin
      if (s_u != 4'd9) begin
        n_s_u = s_u + 4'd1;
      end else begin
        n_s_u = 4'd0;
        if (s_t != 4'd5) begin
          n_s_t = s_t + 4'd1;
        end else begin
          n_s_t = 4'd0;
          if (m_u != 4'd9) begin
            n_m_u = m_u + 4'd1;
          end else begin
            n_m_u = 4'd0;
            if (m_t != 4'd5) begin
              n_m_t = m_t + 4'd1;
            end else begin
              n_m_t = 4'd0;
              if (MODE_12H && h_t == 4'd1 && h_u == 4'd2) begin
                n_h_t = 4'd0;
                n_h_u = 4'd1;
              end else if (MODE_12H && h_t == 4'd1 && h_u == 4'd1) begin
                n_h_t = 4'd1;
                n_h_u = 4'd2;
                n_pm  = ~pm_q;
              end else if (!MODE_12H && h_t == 4'd2 && h_u == 4'd3) begin
                n_h_t = 4'd0;
                n_h_u = 4'd0;
              end else if (h_u == 4'd9) begin
                n_h_t = h_t + 4'd1;
                n_h_u = 4'd0;
              end else begin
                n_h_u = h_u + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // LED i is bit (i mod 4) of digit (i div 4); seconds-off drops the two low digits.
  assign digits     = {n_h_t, n_h_u, n_m_t, n_m_u, n_s_t, n_s_u};
  assign frame_bits = NUM_LEDS'(SHOW_SECONDS ? digits : (digits >> 8));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_t        <= MODE_12H ? 4'd1 : 4'd0;
      h_u        <= MODE_12H ? 4'd2 : 4'd0;
      m_t        <= 4'd0;
      m_u        <= 4'd0;
      s_t        <= 4'd0;
      s_u        <= 4'd0;
      pm_q       <= 1'b0;
      presc      <= '0;
      sec_pulse  <= 1'b0;
      load_err   <= 1'b0;
      state      <= IDLE;
      pending    <= 1'b1;
      fb         <= '0;
      write      <= 1'b0;
      led_num    <= 8'd0;
      rgb_data   <= 24'd0;
      frame_done <= 1'b0;
    end else begin
      h_t        <= n_h_t;
      h_u        <= n_h_u;
      m_t        <= n_m_t;
      m_u        <= n_m_u;
      s_t        <= n_s_t;
      s_u        <= n_s_u;
      pm_q       <= n_pm;
      presc      <= (load_ok || presc == PRESC_MAX) ? '0 : presc + PW'(1);
      sec_pulse  <= tick;
      load_err   <= load && !load_ok;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            fb       <= frame_bits >> 1;
            rgb_data <= frame_bits[0] ? ON_COLOR : OFF_COLOR;
            led_num  <= 8'd0;
            write    <= 1'b1;
            pending  <= 1'b0;
            state    <= STREAM;
          end else begin
            write <= 1'b0;
          end
        end
        STREAM: begin
          if (tick || load_ok) pending <= 1'b1;
          if (led_num == LAST_LED) begin
            write      <= 1'b0;
            rgb_data   <= 24'd0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            led_num  <= led_num + 8'd1;
            rgb_data <= fb[0] ? ON_COLOR : OFF_COLOR;
            fb       <= fb >> 1;
            write    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hh = {h_t, h_u};
  assign mm = {m_t, m_u};
  assign ss = {s_t, s_u};
  assign pm = MODE_12H ? pm_q : 1'b0;

endmodule

// File: tb/tb_bcd_clock_pixel_driver.sv
// Two clock instances (24h/seconds, 12h/HH:MM) checked every cycle against a seconds-of-day model.
module tb_bcd_clock_pixel_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        ld  [2];
  logic [7:0]  lh  [2];
  logic [7:0]  lm  [2];
  logic [7:0]  ls  [2];
  logic        lpm [2];
  logic [7:0]  hh_o [2];
  logic [7:0]  mm_o [2];
  logic [7:0]  ss_o [2];
  logic [7:0]  led_o[2];
  logic        pm_o [2];
  logic        sp_o [2];
  logic        le_o [2];
  logic        wr_o [2];
  logic        fd_o [2];
  logic [23:0] rgb_o[2];

  int          td   [2] = '{4, 30};
  bit          m12  [2] = '{1'b0, 1'b1};
  bit          shs  [2] = '{1'b1, 1'b0};
  int          nl   [2] = '{24, 16};
  logic [23:0] onc  [2] = '{24'h101010, 24'hFF0080};
  logic [23:0] offc [2] = '{24'h000000, 24'h000102};

  bcd_clock_pixel_driver #(.TICK_DIV(4), .MODE_12H(1'b0), .SHOW_SECONDS(1'b1),
                           .ON_COLOR(24'h101010), .OFF_COLOR(24'h000000)) u0 (
    .clk(clk), .reset(rst[0]), .load(ld[0]), .load_h(lh[0]), .load_m(lm[0]), .load_s(ls[0]),
    .load_pm(lpm[0]), .hh(hh_o[0]), .mm(mm_o[0]), .ss(ss_o[0]), .pm(pm_o[0]),
    .sec_pulse(sp_o[0]), .load_err(le_o[0]), .rgb_data(rgb_o[0]), .led_num(led_o[0]),
    .write(wr_o[0]), .frame_done(fd_o[0]));

  bcd_clock_pixel_driver #(.TICK_DIV(30), .MODE_12H(1'b1), .SHOW_SECONDS(1'b0),
                           .ON_COLOR(24'hFF0080), .OFF_COLOR(24'h000102)) u1 (
    .clk(clk), .reset(rst[1]), .load(ld[1]), .load_h(lh[1]), .load_m(lm[1]), .load_s(ls[1]),
    .load_pm(lpm[1]), .hh(hh_o[1]), .mm(mm_o[1]), .ss(ss_o[1]), .pm(pm_o[1]),
    .sec_pulse(sp_o[1]), .load_err(le_o[1]), .rgb_data(rgb_o[1]), .led_num(led_o[1]),
    .write(wr_o[1]), .frame_done(fd_o[1]));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_valid(input bit mode12, input logic [7:0] h, m, s);
    int hv, mv, sv;
    if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
      return 1'b0;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    mv = int'(m[7:4]) * 10 + int'(m[3:0]);
    sv = int'(s[7:4]) * 10 + int'(s[3:0]);
    if (mv > 59 || sv > 59) return 1'b0;
    return mode12 ? (hv >= 1 && hv <= 12) : (hv <= 23);
  endfunction

  function automatic int load_secs(input bit mode12, input logic [7:0] h, m, s, input logic p);
    int hv;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (mode12) hv = (hv % 12) + (p ? 12 : 0);
    return hv * 3600 + (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  function automatic int disp_hour(input bit mode12, input int t);
    int h;
    h = t / 3600;
    if (mode12) return (h % 12 == 0) ? 12 : h % 12;
    return h;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit led_bit(input bit mode12, input bit secs, input int t, input int i);
    int s, m, h;
    int d[6];
    s = t % 60;
    m = (t / 60) % 60;
    h = disp_hour(mode12, t);
    d = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    return bit'((d[i / 4 + (secs ? 0 : 2)] >> (i % 4)) & 1);
  endfunction

  // Reference state: time as seconds since midnight, frames tracked by "owed" flag.
  int tsec [2];
  int presc[2];
  bit e_sp [2];
  bit e_le [2];
  bit r    [2];
  bit dirty[2];
  int wc   [2];
  int ft   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      r[k] = rst[k];
      if (rst[k]) begin
        tsec[k] = 0; presc[k] = 0; e_sp[k] = 0; e_le[k] = 0; dirty[k] = 1; wc[k] = 0;
      end else begin
        bit ok;
        ok = ld[k] && load_valid(m12[k], lh[k], lm[k], ls[k]);
        e_sp[k] = 0;
        e_le[k] = ld[k] && !ok;
        if (ok) begin
          tsec[k] = load_secs(m12[k], lh[k], lm[k], ls[k], lpm[k]);
          presc[k] = 0;
          dirty[k] = 1;
        end else if (presc[k] == td[k] - 1) begin
          presc[k] = 0;
          tsec[k] = (tsec[k] + 1) % 86400;
          e_sp[k] = 1;
          dirty[k] = 1;
        end else begin
          presc[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit done_e;
      check_eq($sformatf("hh[%0d]", k), hh_o[k], bcd(disp_hour(m12[k], tsec[k])));
      check_eq($sformatf("mm[%0d]", k), mm_o[k], bcd((tsec[k] / 60) % 60));
      check_eq($sformatf("ss[%0d]", k), ss_o[k], bcd(tsec[k] % 60));
      check_eq($sformatf("pm[%0d]", k), pm_o[k], m12[k] && tsec[k] >= 43200);
      check_eq($sformatf("sec_pulse[%0d]", k), sp_o[k], e_sp[k]);
      check_eq($sformatf("load_err[%0d]", k), le_o[k], e_le[k]);
      if (r[k]) begin
        check_eq($sformatf("rst_write[%0d]", k), wr_o[k], 0);
        check_eq($sformatf("rst_done[%0d]", k), fd_o[k], 0);
        check_eq($sformatf("rst_led[%0d]", k), led_o[k], 0);
        check_eq($sformatf("rst_rgb[%0d]", k), rgb_o[k], 0);
      end else begin
        done_e = (wc[k] == nl[k]);
        check_eq($sformatf("frame_done[%0d]", k), fd_o[k], done_e);
        if (done_e) begin
          check_eq($sformatf("gap_write[%0d]", k), wr_o[k], 0);
          wc[k] = 0;
        end else if (wc[k] > 0) begin
          check_eq($sformatf("cont_write[%0d]", k), wr_o[k], 1);
        end else begin
          check_eq($sformatf("start_write[%0d]", k), wr_o[k], dirty[k]);
        end
        if (!done_e && wr_o[k]) begin
          check_eq($sformatf("led_num[%0d]", k), led_o[k], wc[k]);
          if (wc[k] == 0) begin
            ft[k] = tsec[k];
            dirty[k] = 0;
          end
          check_eq($sformatf("rgb[%0d]", k), rgb_o[k],
                   led_bit(m12[k], shs[k], ft[k], wc[k]) ? onc[k] : offc[k]);
          wc[k]++;
        end
      end
    end
  end

  task automatic do_load(input int k, input logic [7:0] h, m, s, input logic p);
    ld[k] = 1'b1; lh[k] = h; lm[k] = m; ls[k] = s; lpm[k] = p;
    @(negedge clk);
    ld[k] = 1'b0;
  endtask

  task automatic wait_pulse(input int k, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sp_o[k]) break;
    end
    check_eq($sformatf("wait_sec_pulse[%0d]", k), sp_o[k], 1);
  endtask

  task automatic wait_led(input int k, input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (wr_o[k] && led_o[k] == 8'(n)) break;
    end
    check_eq($sformatf("wait_led%0d[%0d]", n, k), wr_o[k] && led_o[k] == 8'(n), 1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ld[k] = 1'b0; lh[k] = 8'h00; lm[k] = 8'h00; ls[k] = 8'h00; lpm[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (60) @(negedge clk);

    // 24h rollover across midnight
    do_load(0, 8'h23, 8'h59, 8'h58, 1'b0);
    wait_pulse(0, 10);
    check_eq("roll_ss59", ss_o[0], 8'h59);
    wait_pulse(0, 10);
    check_eq("roll_hh", hh_o[0], 8'h00);
    check_eq("roll_mmss", {mm_o[0], ss_o[0]}, 16'h0000);
    repeat (30) @(negedge clk);

    // 12h: 11->12 sets pm, 12->01 keeps it
    do_load(1, 8'h11, 8'h59, 8'h59, 1'b0);
    wait_pulse(1, 40);
    check_eq("h12_noon_hh", hh_o[1], 8'h12);
    check_eq("h12_noon_pm", pm_o[1], 1);
    do_load(1, 8'h12, 8'h59, 8'h59, 1'b1);
    wait_pulse(1, 40);
    check_eq("h12_one_hh", hh_o[1], 8'h01);
    check_eq("h12_one_pm", pm_o[1], 1);

    // rejected loads
    do_load(0, 8'h24, 8'h00, 8'h00, 1'b0);
    check_eq("rej_h24", le_o[0], 1);
    do_load(1, 8'h00, 8'h10, 8'h00, 1'b0);
    check_eq("rej_h00", le_o[1], 1);
    do_load(0, 8'h10, 8'h5A, 8'h00, 1'b0);
    check_eq("rej_m5A", le_o[0], 1);
    do_load(1, 8'h05, 8'h00, 8'h60, 1'b0);
    check_eq("rej_s60", le_o[1], 1);
    repeat (40) @(negedge clk);

    // load mid-frame
    wait_led(1, 10, 200);
    do_load(1, 8'h07, 8'h45, 8'h00, 1'b1);
    repeat (80) @(negedge clk);

    // HH:MM frame with reset mid-frame
    do_load(1, 8'h12, 8'h34, 8'h00, 1'b0);
    wait_led(1, 7, 60);
    rst[1] = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_write", wr_o[1], 0);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (40) @(negedge clk);

    // random loads and resets on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        ld[k]  = ($urandom_range(0, 15) == 0);
        rst[k] = ($urandom_range(0, 299) == 0);
        lpm[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          lh[k] = 8'($urandom); lm[k] = 8'($urandom); ls[k] = 8'($urandom);
        end else begin
          lh[k] = {4'($urandom_range(0, m12[k] ? 1 : 2)), 4'($urandom_range(0, 9))};
          lm[k] = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
          ls[k] = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      ld[k] = 1'b0;
      rst[k] = 1'b0;
    end
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_clock_pixel_driver.md
Name: bcd_clock_pixel_driver

Overview:
Parametrised successor of the binary wall-clock datapath. Holds time of day as BCD digits, advancing it from an internal 1 Hz prescaler, with 12/24-hour modes and a validated time-load port. On every time change it streams a coherent frame of per-LED colours into the ws2812 core's `rgb_data`/`led_num`/`write` interface, one LED per clock.

Parameters:
TICK_DIV, 12000000, clk cycles per second tick; minimum 2.
MODE_12H, 0, 0 = 00..23 hours; 1 = 01..12 hours with PM flag.
SHOW_SECONDS, 1, 1 = six digits (NUM_LEDS = 24); 0 = four digits HH:MM (NUM_LEDS = 16).
ON_COLOR, 24'h10_10_10, colour for a set bit.
OFF_COLOR, 24'h00_00_00, colour for a clear bit.

Ports:
clk  in  1  system clock (hwclk domain)
reset  in  1  synchronous, active-high
load  in  1  one-cycle strobe: load time from load_* inputs
load_h  in  8  BCD hours {tens[7:4], units[3:0]}
load_m  in  8  BCD minutes
load_s  in  8  BCD seconds
load_pm  in  1  PM flag for load; ignored when MODE_12H=0
hh  out  8  current BCD hours
mm  out  8  current BCD minutes
ss  out  8  current BCD seconds
pm  out  1  PM flag; constant 0 when MODE_12H=0
sec_pulse  out  1  one-cycle pulse on each tick advance
load_err  out  1  one-cycle pulse when a load is rejected
rgb_data  out  24  colour for led_num; valid while write=1
led_num  out  8  LED index being written
write  out  1  rgb_data/led_num valid this cycle
frame_done  out  1  one-cycle pulse, cycle after the last write of a frame

Behaviour:
- Reset values:
  - MODE_12H=0: hh=00, mm=00, ss=00, pm=0.
  - MODE_12H=1: hh=12, mm=00, ss=00, pm=0.
  - Prescaler=0; all pulse outputs, write, led_num and rgb_data=0; FSM=IDLE; pending=1 (so an initial frame starts the first cycle after reset deasserts).
- Prescaler: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, the time advances by 1 s and sec_pulse=1 the next cycle; the first tick after reset is on cycle TICK_DIV.
- Advance: ss units 9->0 carries to ss tens; 59->00 carries to mm, same rule; mm 59->00 carries to hh.
  - 24h: hh 23->00.
  - 12h: hh 12->01; 11->12 toggles pm; 09->10 is a tens carry.
- Load:
  - Accepted only if every digit is <=9, mm<=59, ss<=59, and hh is in 00..23 (24h) or 01..12 (12h).
  - Accepted: registers update the next cycle, prescaler clears to 0, and a frame is triggered.
  - Rejected: state unchanged, load_err=1 for one cycle.
  - Load beats a coincident tick: the tick is discarded and sec_pulse is not asserted.
- FSM IDLE/STREAM:
  - IDLE: if a trigger (tick advance, accepted load, or pending) is present, snapshot hh/mm/ss into a frame buffer, clear pending, and go to STREAM with index=0.
  - STREAM: write=1, led_num=index, rgb_data=bit?ON_COLOR:OFF_COLOR; index increments each cycle. After index NUM_LEDS-1: return to IDLE, frame_done=1 the next cycle.
  - Exactly NUM_LEDS consecutive write cycles per frame, no gaps.
- Bit mapping: LED i shows bit (i mod 4) of digit (i div 4).
  - SHOW_SECONDS=1 digit order: s_units, s_tens, m_units, m_tens, h_units, h_tens.
  - SHOW_SECONDS=0 order starts at m_units.
  - pm is not displayed.
- Trigger during STREAM: set pending; the current frame completes using its snapshot. The next frame starts from IDLE the cycle after frame_done, using the time current at that moment. Multiple triggers collapse into one pending frame.
- Latency: trigger in IDLE -> first write 1 cycle later.
- Reset mid-frame: frame aborts immediately, write=0, then the initial frame re-runs after reset.
- TICK_DIV < NUM_LEDS+2: frames may back-to-back via pending; no tick is ever lost.

Test Plan:
1. TICK_DIV=4, 24h, release reset -> one 24-write frame with all LEDs OFF_COLOR; sec_pulse at cycle 4; ss=01; next frame LED0=ON_COLOR, LEDs1..23 OFF.
2. load 23:59:58 (24h), TICK_DIV=4, run 2 ticks -> 23:59:59 then 00:00:00; frame after the second tick all OFF.
3. MODE_12H=1, load 11:59:59 pm=0, one tick -> hh=12, mm=00, ss=00, pm=1. Load 12:59:59 -> next tick gives 01:00:00 with pm unchanged.
4. Reject cases: load_h=8'h24 (24h), 8'h00 (12h), load_m=8'h5A, load_s=8'h60 -> load_err pulse each; time unchanged; no frame triggered.
5. Load at index 10 of a frame with TICK_DIV=30 -> current frame finishes with old snapshot; the new frame starts the cycle after frame_done showing loaded time; prescaler restarted (next sec_pulse 30 cycles after load).
6. SHOW_SECONDS=0, hh=12, mm=34 -> 16 writes; LED order m_units=4, m_tens=3, h_units=2, h_tens=1 bit patterns; reset asserted at write 7 -> write drops that cycle, initial frame replays after release.
